// File: rtl/oc8051_ifetch_if.sv
// oc8051_ifetch_if
//   Bundle of the code-memory, external code bus and decoder-window signals
//   used by the oc8051 instruction-fetch unit.
//   Ports (master = fetch unit):
//     rom_addr      out 16  internal ROM address (equals the fetch pointer)
//     rom_ea_int    in  1   rom_addr lies in the internal ROM
//     rom_data1..3  in  8   ROM bytes at rom_addr, +1, +2 (one cycle late)
//     ext_addr      out 16  external code bus address
//     ext_stb       out 1   external read request
//     ext_ack       in  1   external read data valid (single cycle)
//     ext_data      in  8   external read byte
//     pc_load       in  1   jump / flush request
//     pc_new        in  16  new program counter
//     instr_valid   out 1   3-byte instruction window available
//     instr_ready   in  1   decoder accepts the window
//     dec_len       in  2   bytes consumed on accept (0 counts as 1)
//     op1..op3      out 8   window bytes at instr_pc, +1, +2
//     instr_pc      out 16  address of op1
interface oc8051_ifetch_if;
  logic [15:0] rom_addr;
  logic        rom_ea_int;
  logic [7:0]  rom_data1;
  logic [7:0]  rom_data2;
  logic [7:0]  rom_data3;
  logic [15:0] ext_addr;
  logic        ext_stb;
  logic        ext_ack;
  logic [7:0]  ext_data;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  dec_len;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic [7:0]  op3;
  logic [15:0] instr_pc;

  modport master (
    output rom_addr, ext_addr, ext_stb, instr_valid, op1, op2, op3, instr_pc,
    input  rom_ea_int, rom_data1, rom_data2, rom_data3, ext_ack, ext_data,
           pc_load, pc_new, instr_ready, dec_len
  );

  modport slave (
    input  rom_addr, ext_addr, ext_stb, instr_valid, op1, op2, op3, instr_pc,
    output rom_ea_int, rom_data1, rom_data2, rom_data3, ext_ack, ext_data,
           pc_load, pc_new, instr_ready, dec_len
  );
endinterface

// File: rtl/oc8051_ifetch.sv
// oc8051_ifetch
//   Instruction-fetch initiator of the oc8051 core. Fetches code bytes from the
//   internal ROM (three bytes per read) or, above the internal range, from a
//   byte-wide strobe/ack external bus, queues them in order and presents a
//   3-byte window plus its PC to the decoder with a valid/ready handshake.
//   A PC load flushes the queue and restarts fetching at the new address.
//   Ports:
//     clk   clock, all state changes on posedge
//     rst   asynchronous active-low reset
//     bus   oc8051_ifetch_if.master (ROM port, external bus, decoder window)
module oc8051_ifetch #(
  parameter int INT_ROM_WID = 7,
  parameter int DEPTH       = 8
) (
  input logic             clk,
  input logic             rst,
  oc8051_ifetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ROM_RD = 2'd1,
    EXT_RD = 2'd2
  } state_e;

  state_e        state_r;
  state_e        state_nxt_s;
  logic [15:0]   fptr_r;
  logic [15:0]   fptr_nxt_s;
  logic [15:0]   hpc_r;
  logic [15:0]   ext_addr_r;
  logic [15:0]   ext_addr_nxt_s;
  logic          ext_stb_r;
  logic          ext_stb_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] free_s;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [7:0]    mem_r [DEPTH];
  logic [1:0]    push_n_s;
  logic [1:0]    pop_n_s;
  logic [1:0]    int_n_s;
  logic [7:0]    push_byte_s [3];
  logic          valid_s;
  logic          accept_s;

  // An address is internal when every bit above the ROM index is zero.
  function automatic logic is_internal(input logic [15:0] a);
    return ((a >> INT_ROM_WID) == 16'd0);
  endfunction

  assign free_s   = CW'(DEPTH) - cnt_r;
  assign valid_s  = (cnt_r >= CW'(3)) && !bus.pc_load;
  assign accept_s = valid_s && bus.instr_ready;
  assign pop_n_s  = accept_s ? ((bus.dec_len == 2'd0) ? 2'd1 : bus.dec_len) : 2'd0;

  // Internal addresses are contiguous from fptr, so counting the internal ones
  // among fptr..fptr+2 gives the length of the usable ROM prefix.
  assign int_n_s = {1'b0, is_internal(fptr_r)}
                 + {1'b0, is_internal(fptr_r + 16'd1)}
                 + {1'b0, is_internal(fptr_r + 16'd2)};

  assign bus.rom_addr    = fptr_r;
  assign bus.ext_addr    = ext_addr_r;
  assign bus.ext_stb     = ext_stb_r;
  assign bus.instr_valid = valid_s;
  assign bus.op1         = mem_r[rd_ptr_r];
  assign bus.op2         = mem_r[rd_ptr_r + PW'(1)];
  assign bus.op3         = mem_r[rd_ptr_r + PW'(2)];
  assign bus.instr_pc    = hpc_r;

  // Select the bytes offered to the queue this cycle.
  always_comb begin
    push_byte_s[0] = bus.rom_data1;
    push_byte_s[1] = bus.rom_data2;
    push_byte_s[2] = bus.rom_data3;
    if (state_r == EXT_RD) begin
      push_byte_s[0] = bus.ext_data;
    end else begin
      push_byte_s[0] = bus.rom_data1;
    end
  end

  // Fetch FSM next state, fetch pointer, external request and push count.
  always_comb begin
    state_nxt_s    = state_r;
    fptr_nxt_s     = fptr_r;
    ext_stb_nxt_s  = ext_stb_r;
    ext_addr_nxt_s = ext_addr_r;
    push_n_s       = 2'd0;
    if (bus.pc_load) begin
      // Flush: in-flight ROM data and a coinciding ext_ack are dropped.
      state_nxt_s   = FILL;
      fptr_nxt_s    = bus.pc_new;
      ext_stb_nxt_s = 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          // Free space is judged on registered cnt, so a concurrent pop is
          // ignored and the queue can never overflow.
          if (bus.rom_ea_int && (free_s >= CW'(3))) begin
            state_nxt_s = ROM_RD;
          end else if (!bus.rom_ea_int && (cnt_r < CW'(DEPTH))) begin
            state_nxt_s    = EXT_RD;
            ext_stb_nxt_s  = 1'b1;
            ext_addr_nxt_s = fptr_r;
          end else begin
            state_nxt_s = FILL;
          end
        end
        ROM_RD: begin
          push_n_s    = int_n_s;
          fptr_nxt_s  = fptr_r + {14'd0, int_n_s};
          state_nxt_s = FILL;
        end
        EXT_RD: begin
          if (bus.ext_ack) begin
            push_n_s      = 2'd1;
            fptr_nxt_s    = fptr_r + 16'd1;
            ext_stb_nxt_s = 1'b0;
            state_nxt_s   = FILL;
          end else begin
            state_nxt_s = EXT_RD;
          end
        end
        default: begin
          state_nxt_s   = FILL;
          ext_stb_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch pointer, external bus request and byte queue bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fptr_r     <= 16'd0;
      hpc_r      <= 16'd0;
      cnt_r      <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      ext_stb_r  <= 1'b0;
      ext_addr_r <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else begin
      fptr_r     <= fptr_nxt_s;
      ext_stb_r  <= ext_stb_nxt_s;
      ext_addr_r <= ext_addr_nxt_s;
      if (bus.pc_load) begin
        hpc_r    <= bus.pc_new;
        cnt_r    <= '0;
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (2'(k) < push_n_s) begin
            mem_r[wr_ptr_r + PW'(k)] <= push_byte_s[k];
          end
        end
        wr_ptr_r <= wr_ptr_r + PW'(push_n_s);
        rd_ptr_r <= rd_ptr_r + PW'(pop_n_s);
        hpc_r    <= hpc_r + {14'd0, pop_n_s};
        cnt_r    <= cnt_r + CW'(push_n_s) - CW'(pop_n_s);
      end
    end
  end

endmodule

// File: tb/tb_oc8051_ifetch.sv
`timescale 1ns/1ps
// tb_oc8051_ifetch
//   Self-checking bench: a code-memory image (internal ROM array plus an
//   address-derived external byte) and a decoder-side PC tracker predict every
//   presented window; directed scenarios plus a randomized phase.
module tb_oc8051_ifetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [7:0]  rom [128];
  logic [15:0] m_hpc;
  logic [15:0] last_addr;
  logic        obs_valid;
  logic        obs_stb;
  logic [15:0] obs_pc;
  logic [7:0]  obs_op1;
  logic [7:0]  obs_op2;
  logic [7:0]  obs_op3;
  int          ext_wait;
  int          ext_lat;
  bit          ext_en;
  bit          ext_force;
  bit          rand_lat;
  logic        prev_stb;
  logic [15:0] prev_eaddr;
  int          inv_run;

  oc8051_ifetch_if bus ();

  oc8051_ifetch #(.INT_ROM_WID(7), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_ea_int = (bus.rom_addr[15:7] == 9'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ext_byte(input logic [15:0] a);
    return (a[7:0] + 8'h25) ^ a[15:8];
  endfunction

  function automatic logic [7:0] code_byte(input logic [15:0] a);
    if (a[15:7] == 9'd0) return rom[a[6:0]];
    return ext_byte(a);
  endfunction

  function automatic logic [7:0] rom_at(input logic [15:0] a);
    return rom[a[6:0]];
  endfunction

  // One clock cycle: drive memories, observe at negedge+1, update model.
  task automatic step();
    bus.rom_data1 = rom_at(last_addr);
    bus.rom_data2 = rom_at(last_addr + 16'd1);
    bus.rom_data3 = rom_at(last_addr + 16'd2);
    if (bus.ext_stb) begin
      if (ext_force) begin
        bus.ext_ack  = 1'b1;
        bus.ext_data = 8'hEE;
      end else if (ext_en && (ext_wait >= ext_lat)) begin
        bus.ext_ack  = 1'b1;
        bus.ext_data = ext_byte(bus.ext_addr);
      end else begin
        bus.ext_ack  = 1'b0;
      end
      ext_wait++;
    end else begin
      bus.ext_ack = 1'b0;
      ext_wait    = 0;
      if (rand_lat) ext_lat = $urandom_range(0, 3);
    end
    #1;
    obs_valid = bus.instr_valid;
    obs_stb   = bus.ext_stb;
    obs_pc    = bus.instr_pc;
    obs_op1   = bus.op1;
    obs_op2   = bus.op2;
    obs_op3   = bus.op3;
    if (bus.pc_load) begin
      check_value("valid_in_load", bus.instr_valid, 1'b0);
    end else if (bus.instr_valid) begin
      check_value("win_pc", bus.instr_pc, m_hpc);
      check_value("win_op1", bus.op1, code_byte(m_hpc));
      check_value("win_op2", bus.op2, code_byte(m_hpc + 16'd1));
      check_value("win_op3", bus.op3, code_byte(m_hpc + 16'd2));
    end
    if (bus.ext_stb && prev_stb) check_value("ext_addr_hold", bus.ext_addr, prev_eaddr);
    prev_stb   = bus.ext_stb;
    prev_eaddr = bus.ext_addr;
    if (bus.pc_load) begin
      m_hpc = bus.pc_new;
    end else if (bus.instr_valid && bus.instr_ready) begin
      m_hpc = m_hpc + ((bus.dec_len == 2'd0) ? 16'd1 : {14'd0, bus.dec_len});
    end
    if (!bus.instr_valid && !bus.pc_load) inv_run++;
    else inv_run = 0;
    if (inv_run == 40) begin
      check_value("live_valid", bus.instr_valid, 1'b1);
      inv_run = 0;
    end
    last_addr = bus.rom_addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.pc_load = 1'b0; bus.pc_new = 16'd0; bus.instr_ready = 1'b0; bus.dec_len = 2'd0;
    bus.ext_ack = 1'b0; bus.ext_data = 8'd0;
    bus.rom_data1 = 8'd0; bus.rom_data2 = 8'd0; bus.rom_data3 = 8'd0;
    ext_force = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_value("rst_valid", bus.instr_valid, 1'b0);
    check_value("rst_pc", bus.instr_pc, 16'd0);
    check_value("rst_ops", {bus.op1, bus.op2, bus.op3}, 24'd0);
    check_value("rst_rom_addr", bus.rom_addr, 16'd0);
    check_value("rst_ext", {bus.ext_stb, bus.ext_addr}, 17'd0);
    @(negedge clk);
    rst = 1'b1;
    m_hpc = 16'd0; last_addr = 16'd0; ext_wait = 0; prev_stb = 1'b0; inv_run = 0;
  endtask

  task automatic load(input logic [15:0] a);
    bus.pc_load = 1'b1;
    bus.pc_new = a;
    bus.instr_ready = 1'b0;
    step();
    check_value("load_valid", obs_valid, 1'b0);
    bus.pc_load = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    for (int i = 0; i < 20 && !obs_stb; i++) step();
    check_value({tag, "_stb_seen"}, obs_stb, 1'b1);
  endtask

  task automatic accept_expect(input string tag, input logic [15:0] pc,
                               input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input logic [1:0] len);
    bit got;
    got = 1'b0;
    bus.instr_ready = 1'b1;
    bus.dec_len = len;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = obs_valid;
    end
    bus.instr_ready = 1'b0;
    check_value({tag, "_seen"}, got, 1'b1);
    check_value({tag, "_pc"}, obs_pc, pc);
    check_value({tag, "_ops"}, {obs_op1, obs_op2, obs_op3}, {b1, b2, b3});
  endtask

  initial begin
    int sel;
    n_checks = 0; n_pass = 0;
    for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h35; rom[3] = 8'h90;
    rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h74;
    rom[8'h35] = 8'h78; rom[8'h36] = 8'h7F; rom[8'h37] = 8'hE4;
    rom[8'h7E] = 8'h12; rom[8'h7F] = 8'h34;
    ext_en = 1'b1; ext_lat = 0; rand_lat = 1'b0; obs_stb = 1'b0;
    rst = 1'b1;
    #1;
    do_reset();

    // Startup latency and initial window
    step(); check_value("t1_c0_valid", obs_valid, 1'b0);
    step(); check_value("t1_c1_valid", obs_valid, 1'b0);
    step(); check_value("t1_c2_valid", obs_valid, 1'b1);
    check_value("t1_pc", obs_pc, 16'h0000);
    check_value("t1_ops", {obs_op1, obs_op2, obs_op3}, 24'h020035);

    // Stall with ready low: fetch stops at 6 bytes, window held
    for (int i = 0; i < 25; i++) step();
    check_value("t3_rom_addr", bus.rom_addr, 16'h0006);
    check_value("t3_no_ext", bus.ext_stb, 1'b0);
    check_value("t3_hold", {obs_pc, obs_op1, obs_op2, obs_op3}, 40'h0000020035);

    // Consume with mixed lengths
    accept_expect("t2a", 16'h0000, 8'h02, 8'h00, 8'h35, 2'd3);
    accept_expect("t2b", 16'h0003, 8'h90, 8'h00, 8'h00, 2'd1);
    accept_expect("t2c", 16'h0004, 8'h00, 8'h00, 8'h74, 2'd1);

    // Jump mid-stream
    load(16'h0035);
    accept_expect("t4", 16'h0035, 8'h78, 8'h7F, 8'hE4, 2'd1);

    // Internal/external boundary
    ext_lat = 3;
    load(16'h007E);
    wait_stb("t5");
    check_value("t5_ext_addr", bus.ext_addr, 16'h0080);
    accept_expect("t5", 16'h007E, 8'h12, 8'h34, 8'hA5, 2'd1);

    // Load coinciding with ext_ack drops the byte
    ext_en = 1'b0;
    load(16'h0100);
    wait_stb("t6");
    ext_force = 1'b1; bus.pc_load = 1'b1; bus.pc_new = 16'h0000;
    step();
    ext_force = 1'b0; bus.pc_load = 1'b0;
    check_value("t6_stb_drop", bus.ext_stb, 1'b0);
    ext_en = 1'b1;
    accept_expect("t6", 16'h0000, 8'h02, 8'h00, 8'h35, 2'd3);

    // Asynchronous reset during an external read
    ext_en = 1'b0;
    load(16'h0100);
    wait_stb("t6r");
    #2;
    rst = 1'b0;
    #1;
    check_value("t6_async_stb", bus.ext_stb, 1'b0);
    ext_en = 1'b1;
    do_reset();

    // Randomized traffic with jumps, wrap-around and random ext latency
    rand_lat = 1'b1;
    for (int c = 0; c < 800; c++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.dec_len = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        bus.pc_load = 1'b1;
        sel = $urandom_range(0, 9);
        case (sel)
          0:       bus.pc_new = 16'hFFFD;
          1:       bus.pc_new = 16'h007C + 16'($urandom_range(0, 3));
          default: bus.pc_new = 16'($urandom_range(0, 255));
        endcase
      end else begin
        bus.pc_load = 1'b0;
      end
      step();
    end
    bus.pc_load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oc8051_ifetch.md
Name: oc8051_ifetch

Overview:
Instruction-fetch initiator for the oc8051 core, sitting between the decoder and code memory. It drives the code-memory address port and captures the three-byte registered read from the internal ROM when the address is internal. It falls back to a byte-wide strobe/ack external code bus when the address is external. Fetched bytes go into a byte queue, which presents a 3-byte instruction window plus its PC to the decoder with a valid/ready handshake; a PC load flushes everything.

Parameters:
INT_ROM_WID, 7, internal ROM holds addresses below 2^INT_ROM_WID.
DEPTH, 8, byte queue depth; power of two, at least 4.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  asynchronous, active-low reset (0 = reset).
rom_addr  out  16  code address to internal ROM; always equals fptr.
rom_ea_int  in  1  1 = rom_addr is internal (combinational from rom_addr).
rom_data1  in  8  ROM byte at rom_addr, registered one cycle.
rom_data2  in  8  ROM byte at rom_addr+1, registered one cycle.
rom_data3  in  8  ROM byte at rom_addr+2, registered one cycle.
ext_addr  out  16  external code bus address.
ext_stb  out  1  external read request.
ext_ack  in  1  external data valid, single-cycle.
ext_data  in  8  external read byte.
pc_load  in  1  jump/flush request.
pc_new  in  16  new PC value.
instr_valid  out  1  the 3-byte window is available.
instr_ready  in  1  decoder accepts the window.
dec_len  in  2  bytes consumed on accept (1..3; 0 is treated as 1).
op1  out  8  queue byte at head.
op2  out  8  queue byte at head+1.
op3  out  8  queue byte at head+2.
instr_pc  out  16  address of op1.

Behaviour:
- State: fptr[15:0] (next byte to fetch), hpc[15:0] (head PC), cnt (0..DEPTH), queue storage, FSM {FILL, ROM_RD, EXT_RD}.
- Reset (rst=0, async): state=FILL, fptr=0, hpc=0, cnt=0, queue storage=0, ext_stb=0, instr_valid=0, op1..op3=0, instr_pc=0, rom_addr=0, ext_addr=0.
- FILL:
  - If rom_ea_int=1 and DEPTH-cnt>=3, go to ROM_RD.
  - Else if rom_ea_int=0 and cnt<DEPTH, go to EXT_RD, with ext_stb=1 and ext_addr=fptr registered on the transition.
  - Else stay in FILL.
- ROM_RD (one cycle):
  - rom_data1..3 are valid this cycle.
  - Push n bytes in order, where n = count of addresses fptr, fptr+1, fptr+2 whose bits [15:INT_ROM_WID] are all zero. n is never 0.
  - fptr += n; return to FILL. Internal fetch throughput is 3 bytes per 2 cycles.
- EXT_RD:
  - ext_stb stays high and ext_addr stays stable until ext_ack.
  - On ack: push ext_data, fptr += 1, ext_stb=0, return to FILL.
  - No request timeout.
- Address arithmetic is 16-bit, wrapping 0xFFFF to 0x0000 (fptr and hpc).
- Output window:
  - instr_valid = (cnt>=3) and no pc_load this cycle. Combinational from registered state and pc_load.
  - op1..op3 = queue[head..head+2]; instr_pc = hpc.
  - op1..op3 and instr_pc are held stable while valid && !ready.
- Accept (valid && ready):
  - Pop L = max(dec_len,1) bytes; hpc += L.
  - A push and a pop in the same cycle are both applied: cnt_next = cnt + pushed - popped.
  - The FILL free-space check uses registered cnt, so it is conservative; overflow is impossible.
- pc_load=1 takes priority over everything:
  - Next edge: cnt=0, fptr=pc_new, hpc=pc_new, state=FILL, ext_stb=0.
  - No accept is taken that cycle.
  - ROM data arriving in ROM_RD is discarded.
  - An ext_ack coinciding with pc_load is ignored and its byte dropped.
- The queue never reorders. Only bytes at consecutive addresses from hpc are ever held.

Test Plan:
1. ROM holds 02 00 35 90 00 00 at 0x0000; rst released, instr_ready=0 -> rom_addr=0000; instr_valid=1 on the 2nd cycle after release with op=02,00,35, instr_pc=0000; fetching stops at cnt=6.
2. Continue from 1 with ready=1, dec_len=3, then dec_len=1 -> windows (0000: 02 00 35), (0003: 90 00 00), (0004: 00 00 74); instr_pc advances by L each time.
3. Hold ready=0 from reset -> cnt saturates at 6 (FILL needs free>=3); no ROM_RD issued; op1..op3 and instr_pc stable for 20 cycles.
4. pc_load with pc_new=0035 mid-stream -> instr_valid=0 in the load cycle; 2 cycles later op=78,7F,E4, instr_pc=0035.
5. pc_load to 007E (INT_ROM_WID=7) -> ROM_RD pushes only 2 bytes (7E, 7F); then ext_stb=1 with ext_addr=0080; ext_ack with ext_data=A5 after 3 cycles -> window 007E: bytes(7E),bytes(7F),A5.
6. Assert pc_load=1 with pc_new=0000 during EXT_RD in the same cycle as ext_ack -> byte dropped; ext_stb=0 next cycle; refetch from 0000 gives op=02,00,35. Separately, pull rst low during EXT_RD -> ext_stb falls immediately, without waiting for a clock edge.
